mq2_alarm_driver: RTL
=====================

Name: mq2_alarm_driver

Overview:
Downstream consumer of the MQ-2 gas-detect stage's active-low alert line. Converts the alert level into an audible intermittent beep pattern: a square-wave tone gated on and off, suitable for a passive buzzer. Adds a minimum alarm hold time after the alert clears and a timed operator mute. Sits between the gas-detect stage and the buzzer pin.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
TONE_HZ, 2000, buzzer tone frequency; TONE_HALF = CLK_FREQ/(2*TONE_HZ) cycles
BEEP_ON_MS, 200, tone-on interval; ON_CYC = (CLK_FREQ/1000)*BEEP_ON_MS
BEEP_OFF_MS, 300, silent interval; OFF_CYC = (CLK_FREQ/1000)*BEEP_OFF_MS
HOLD_MS, 2000, alert-clear time before the alarm stops; HOLD_CYC likewise
MUTE_MS, 10000, mute duration; MUTE_CYC likewise

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low, single clock domain
alert_n  in  1  gas alert from the detect stage; 0 = gas, 1 = normal; same clock domain, no synchronizer
mute  in  1  operator mute level from the debounced button; the rising edge is detected internally
buzzer_pwm  out  1  tone to the passive buzzer; idle low
alarm_active  out  1  high while in ON, OFF or MUTED
muted  out  1  high while in MUTED

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - buzzer_pwm=0, alarm_active=0, muted=0.
  - tone, phase, hold and mute counters all 0.
  - mute_prev=1, so a mute held through reset produces no edge.
  - Reset mid-operation takes effect on that edge, from any state.
- mute_edge = mute & ~mute_prev. mute_prev is registered every cycle.
- All outputs are registered. Counter widths are $clog2 of the terminal count plus 1.
- IDLE:
  - Outputs are 0.
  - alert_n=0 sampled moves to ON at the next edge. At that edge, alarm_active=1 and the tone and phase counters are 0.
  - Latency from alert to alarm_active is 1 cycle.
  - mute_edge is ignored.
- ON:
  - The tone counter runs 0..TONE_HALF-1. At its terminal count, buzzer_pwm toggles and the counter wraps.
  - The phase counter runs 0..ON_CYC-1. At its terminal count the FSM goes to OFF: buzzer_pwm is forced 0, and the tone and phase counters clear.
  - Tone starts low on entry.
- OFF:
  - buzzer_pwm=0.
  - The phase counter runs 0..OFF_CYC-1, then the FSM returns to ON.
  - Steady alarm period = ON_CYC+OFF_CYC.
- Hold (applies in ON, OFF and MUTED):
  - When alert_n=1, the hold counter increments. When alert_n=0, it clears.
  - If the hold counter equals HOLD_CYC-1 and alert_n=1, the FSM goes to IDLE at that edge and all outputs become 0, even mid-beep.
  - Net effect: HOLD_CYC consecutive alert_n=1 samples end the alarm.
- Mute:
  - mute_edge in ON or OFF moves to MUTED. Next cycle: buzzer_pwm=0, muted=1, alarm_active stays 1, mute counter=0.
- MUTED:
  - buzzer_pwm=0.
  - The mute counter runs 0..MUTE_CYC-1. At its terminal count, muted goes to 0 and the FSM goes to ON (fresh phase and tone) if alert_n=0, or to IDLE if alert_n=1.
  - mute_edge in MUTED is ignored; the timer is not restarted.
- Priority within one cycle: reset > hold expiry > mute_edge > phase/mute terminal count.
- Counters never overflow: each wraps or clears only at its terminal count.

Test Plan:
Common bench parameters: CLK_FREQ=10000, TONE_HZ=1000, BEEP_ON_MS=2, BEEP_OFF_MS=3, HOLD_MS=5, MUTE_MS=10. These give TONE_HALF=5, ON=20, OFF=30, HOLD=50, MUTE=100.
1. Hold rst_n=0 with alert_n=0 and mute=1, then release -> all outputs are 0 during reset; alarm_active=1 one cycle after the first post-reset edge; muted stays 0.
2. alert_n falls at edge T -> alarm_active=1 at T+1; buzzer_pwm toggles at T+6, T+11, T+16 and is forced 0 at T+21; it stays low 30 cycles; the pattern repeats every 50 cycles.
3. During the alarm, drive alert_n=1 for 49 cycles then 0 -> the alarm continues uninterrupted. Drive alert_n=1 for 50 cycles -> alarm_active and buzzer_pwm are 0 on the edge sampling the 50th high.
4. With the alarm persistent, pulse mute high for 1 cycle in ON -> next cycle buzzer_pwm=0 and muted=1. A second mute pulse has no effect. After 100 cycles, muted=0 and ON restarts with a fresh tone.
5. In MUTED, raise alert_n for 50 cycles -> the FSM goes to IDLE before mute expiry; muted=0 and alarm_active=0. On the same cycle as hold expiry in ON, a mute edge leaves the FSM in IDLE with muted=0.
6. Assert rst_n=0 mid-ON with buzzer_pwm=1 -> all outputs are 0 on that edge. After release with alert_n=0, the alarm restarts from phase 0.

Source files
------------

// File: rtl/mq2_alarm_driver.sv
// Turns the active-low gas alert into a gated buzzer tone, with a hold time
// after the alert clears and a timed operator mute.
module mq2_alarm_driver #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned TONE_HZ     = 2000,
  parameter int unsigned BEEP_ON_MS  = 200,
  parameter int unsigned BEEP_OFF_MS = 300,
  parameter int unsigned HOLD_MS     = 2000,
  parameter int unsigned MUTE_MS     = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alert_n,
  input  logic mute,
  output logic buzzer_pwm,
  output logic alarm_active,
  output logic muted
);

  localparam int unsigned TONE_HALF = CLK_FREQ / (2 * TONE_HZ);
  localparam int unsigned ON_CYC    = (CLK_FREQ / 1000) * BEEP_ON_MS;
  localparam int unsigned OFF_CYC   = (CLK_FREQ / 1000) * BEEP_OFF_MS;
  localparam int unsigned HOLD_CYC  = (CLK_FREQ / 1000) * HOLD_MS;
  localparam int unsigned MUTE_CYC  = (CLK_FREQ / 1000) * MUTE_MS;
  localparam int unsigned PHASE_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;

  localparam int unsigned TONE_W  = $clog2(TONE_HALF) + 1;
  localparam int unsigned PHASE_W = $clog2(PHASE_CYC) + 1;
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYC) + 1;
  localparam int unsigned MUTE_W  = $clog2(MUTE_CYC) + 1;

  typedef enum logic [1:0] {IDLE, ON, OFF, MUTED} state_t;

  state_t               state, state_nxt;
  logic [TONE_W-1:0]    tone_cnt, tone_nxt;
  logic [PHASE_W-1:0]   phase_cnt, phase_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic [MUTE_W-1:0]    mute_cnt, mute_cnt_nxt;
  logic                 mute_prev;
  logic                 buzzer_nxt, alarm_nxt, muted_nxt;

  logic mute_edge, hold_exp, tone_tc, phase_tc, mute_tc;

  assign mute_edge = mute & ~mute_prev;
  assign hold_exp  = alert_n && (hold_cnt == HOLD_W'(HOLD_CYC - 1));
  assign tone_tc   = (tone_cnt == TONE_W'(TONE_HALF - 1));
  assign phase_tc  = ((state == ON)  && (phase_cnt == PHASE_W'(ON_CYC - 1))) ||
                     ((state == OFF) && (phase_cnt == PHASE_W'(OFF_CYC - 1)));
  assign mute_tc   = (mute_cnt == MUTE_W'(MUTE_CYC - 1));

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      tone_cnt     <= '0;
      phase_cnt    <= '0;
      hold_cnt     <= '0;
      mute_cnt     <= '0;
      mute_prev    <= 1'b1;
      buzzer_pwm   <= 1'b0;
      alarm_active <= 1'b0;
      muted        <= 1'b0;
    end else begin
      state        <= state_nxt;
      tone_cnt     <= tone_nxt;
      phase_cnt    <= phase_nxt;
      hold_cnt     <= hold_nxt;
      mute_cnt     <= mute_cnt_nxt;
      mute_prev    <= mute;
      buzzer_pwm   <= buzzer_nxt;
      alarm_active <= alarm_nxt;
      muted        <= muted_nxt;
    end
  end

  // Next state: hold expiry beats mute, mute beats terminal counts
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!alert_n) state_nxt = ON;
      ON: begin
        if (hold_exp)       state_nxt = IDLE;
        else if (mute_edge) state_nxt = MUTED;
        else if (phase_tc)  state_nxt = OFF;
      end
      OFF: begin
        if (hold_exp)       state_nxt = IDLE;
        else if (mute_edge) state_nxt = MUTED;
        else if (phase_tc)  state_nxt = ON;
      end
      MUTED: begin
        if (hold_exp)     state_nxt = IDLE;
        else if (mute_tc) state_nxt = alert_n ? IDLE : ON;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter and output next values; any state change restarts the local timers
  always_comb begin
    tone_nxt     = '0;
    phase_nxt    = '0;
    hold_nxt     = '0;
    mute_cnt_nxt = '0;
    buzzer_nxt   = 1'b0;
    alarm_nxt    = (state_nxt != IDLE);
    muted_nxt    = (state_nxt == MUTED);

    if (state != IDLE && state_nxt != IDLE)
      hold_nxt = alert_n ? hold_cnt + HOLD_W'(1) : '0;

    if (state == ON && state_nxt == ON) begin
      tone_nxt   = tone_tc ? '0 : tone_cnt + TONE_W'(1);
      phase_nxt  = phase_cnt + PHASE_W'(1);
      buzzer_nxt = tone_tc ? ~buzzer_pwm : buzzer_pwm;
    end

    if (state == OFF && state_nxt == OFF)
      phase_nxt = phase_cnt + PHASE_W'(1);

    if (state == MUTED && state_nxt == MUTED)
      mute_cnt_nxt = mute_cnt + MUTE_W'(1);
  end

endmodule
